// File: rtl/launch_sequencer_pkg.sv
// Shared definitions for the launch sequencer: parameter defaults,
// sequencer states and the field layout of an instruction-memory word.
package launch_sequencer_pkg;

  localparam int DEF_MEM_ADDR_WIDTH   = 10;
  localparam int DEF_INSTR_DATA_WIDTH = 32;
  localparam int DEF_INSTR_ADDR_WIDTH = 6;
  localparam int DEF_INSTR_HOPS_WIDTH = 4;
  localparam int DEF_TIMEOUT_WIDTH    = 16;

  localparam int COUNT_WIDTH   = 9;
  localparam int RD_DATA_WIDTH = 64;

  // Bit offsets of the fields packed into one memory word
  localparam int RD_DATA_LSB = 0;
  localparam int RD_ADDR_LSB = 32;
  localparam int RD_HOPS_LSB = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_CALL,
    ST_WAIT_RET,
    ST_DONE
  } state_t;

endpackage

// File: rtl/launch_sequencer_timeout_cnt.sv
// Return-timeout down-counter. Loaded with the timeout before waiting,
// counts down while enabled and flags expiry in the last allowed cycle.
// A load value of zero never expires.
module launch_timeout_cnt
  import launch_sequencer_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [TIMEOUT_WIDTH-1:0] load_val,
  input  logic                     en,
  output logic                     expire
);

  logic [TIMEOUT_WIDTH-1:0] cnt;

  // Load on request, otherwise count down to zero while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TIMEOUT_WIDTH'(1);
    end
  end

  // Expiry when the final waiting cycle is reached without a return
  assign expire = en && (cnt == TIMEOUT_WIDTH'(1));

endmodule

// File: rtl/launch_sequencer.sv
// Launch sequencer: clears the array, streams count instruction words from
// memory into the cell load chain, calls the kernel and waits for its
// return (optionally bounded by a timeout). Abort cancels at any point.
module launch_sequencer
  import launch_sequencer_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH,
  parameter int INSTR_DATA_WIDTH = DEF_INSTR_DATA_WIDTH,
  parameter int INSTR_ADDR_WIDTH = DEF_INSTR_ADDR_WIDTH,
  parameter int INSTR_HOPS_WIDTH = DEF_INSTR_HOPS_WIDTH,
  parameter int TIMEOUT_WIDTH    = DEF_TIMEOUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [MEM_ADDR_WIDTH-1:0]   base_addr,
  input  logic [COUNT_WIDTH-1:0]      count,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [RD_DATA_WIDTH-1:0]    mem_rd_data,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        instr_en_out,
  output logic                        call_out,
  input  logic                        ret_in,
  output logic                        arr_clr
);

  state_t                     state;
  logic [MEM_ADDR_WIDTH-1:0]  base_lat;
  logic [COUNT_WIDTH-1:0]     count_lat;
  logic [TIMEOUT_WIDTH-1:0]   timeout_lat;
  logic [COUNT_WIDTH-1:0]     rd_left;
  logic [MEM_ADDR_WIDTH-1:0]  rd_addr_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       error_q;
  logic                       arr_clr_q;
  logic                       call_q;
  logic                       rd_en_q;
  logic                       vld_p1;
  logic                       tmo_expire;
  logic                       unused_rd_bits;

  // Upper memory-word bits carry nothing for the load chain
  assign unused_rd_bits = ^mem_rd_data[RD_DATA_WIDTH-1:RD_HOPS_LSB+INSTR_HOPS_WIDTH];

  launch_timeout_cnt #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_CALL),
    .load_val (timeout_lat),
    .en       (state == ST_WAIT_RET),
    .expire   (tmo_expire)
  );

  // Sequencer FSM with registered status and strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      arr_clr_q   <= 1'b0;
      call_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_left     <= '0;
      base_lat    <= '0;
      count_lat   <= '0;
      timeout_lat <= '0;
    end else begin
      done_q    <= 1'b0;
      arr_clr_q <= 1'b0;
      call_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
        state   <= ST_DONE;
        done_q  <= 1'b1;
        error_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state       <= ST_CLEAR;
              busy_q      <= 1'b1;
              arr_clr_q   <= 1'b1;
              error_q     <= 1'b0;
              base_lat    <= base_addr;
              count_lat   <= count;
              timeout_lat <= timeout;
            end
          end
          ST_CLEAR: begin
            if (count_lat != '0) begin
              state     <= ST_FETCH;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_lat;
              rd_left   <= count_lat - COUNT_WIDTH'(1);
            end else begin
              state  <= ST_CALL;
              call_q <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (rd_left == '0) begin
              state <= ST_DRAIN;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_addr_q + MEM_ADDR_WIDTH'(1);
              rd_left   <= rd_left - COUNT_WIDTH'(1);
            end
          end
          ST_DRAIN: begin
            state  <= ST_CALL;
            call_q <= 1'b1;
          end
          ST_CALL: begin
            state <= ST_WAIT_RET;
          end
          ST_WAIT_RET: begin
            if (ret_in) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (tmo_expire) begin
              state   <= ST_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            if (abort) begin
              error_q <= 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read data returns one cycle after the request: track which cycles carry it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= mem_rd_en;
    end
  end

  // Stage p1: abort silences the strobes in the cycle it is raised
  assign mem_rd_en      = rd_en_q & ~abort;
  assign mem_rd_addr    = rd_addr_q;
  assign call_out       = call_q & ~abort;
  assign instr_en_out   = vld_p1 & ~abort;
  assign instr_data_out = instr_en_out ? mem_rd_data[RD_DATA_LSB +: INSTR_DATA_WIDTH] : '0;
  assign instr_addr_out = instr_en_out ? mem_rd_data[RD_ADDR_LSB +: INSTR_ADDR_WIDTH] : '0;
  assign instr_hops_out = instr_en_out ? mem_rd_data[RD_HOPS_LSB +: INSTR_HOPS_WIDTH] : '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign arr_clr        = arr_clr_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// Directed-plus-random bench for launch_sequencer. Expected cycle-by-cycle
// behaviour of each launch is computed from the launch timeline rules.
module tb_launch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [9:0]  base_addr;
  logic [8:0]  count;
  logic [15:0] timeout;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [31:0] instr_data_out;
  logic [5:0]  instr_addr_out;
  logic [3:0]  instr_hops_out;
  logic        instr_en_out;
  logic        call_out;
  logic        ret_in;
  logic        arr_clr;

  logic [63:0] mem [1024];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        model_err = 1'b0;

  launch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .count          (count),
    .timeout        (timeout),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .instr_data_out (instr_data_out),
    .instr_addr_out (instr_addr_out),
    .instr_hops_out (instr_hops_out),
    .instr_en_out   (instr_en_out),
    .call_out       (call_out),
    .ret_in         (ret_in),
    .arr_clr        (arr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= {$urandom, $urandom};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},      64'(busy), 64'd0);
    chk({tag, " done"},      64'(done), 64'd0);
    chk({tag, " error"},     64'(error), 64'd0);
    chk({tag, " rd_en"},     64'(mem_rd_en), 64'd0);
    chk({tag, " rd_addr"},   64'(mem_rd_addr), 64'd0);
    chk({tag, " i_data"},    64'(instr_data_out), 64'd0);
    chk({tag, " i_addr"},    64'(instr_addr_out), 64'd0);
    chk({tag, " i_hops"},    64'(instr_hops_out), 64'd0);
    chk({tag, " i_en"},      64'(instr_en_out), 64'd0);
    chk({tag, " call"},      64'(call_out), 64'd0);
    chk({tag, " arr_clr"},   64'(arr_clr), 64'd0);
  endtask

  // One whole launch starting at cycle 0 (start sampled at the end of cycle 0).
  // ret_at: WAIT_RET-relative cycle when ret_in rises (-1 = never).
  // abort_at: start-relative cycle carrying abort (-1 = none).
  task automatic run_launch(input logic [9:0] base, input int cnt, input logic [15:0] tmo,
                            input int ret_at, input int abort_at, input string name);
    int          call_c, w, done_c;
    logic        exp_err, quiet, exp_rd, exp_ins, errv;
    logic [63:0] word;
    logic [9:0]  a;
    string       t;
    call_c = (cnt > 0) ? 3 + cnt : 2;
    w      = call_c + 1;
    if (abort_at > 0) begin
      done_c = abort_at + 1; exp_err = 1'b1;
    end else if (ret_at >= 0 && (tmo == 0 || ret_at < int'(tmo))) begin
      done_c = w + ret_at + 1; exp_err = 1'b0;
    end else begin
      done_c = w + int'(tmo); exp_err = 1'b1;
    end
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1; base_addr = base; count = cnt[8:0]; timeout = tmo;
      end else begin
        start = (c <= done_c) ? 1'($urandom % 2) : 1'b0;
        base_addr = 10'($urandom); count = 9'($urandom); timeout = 16'($urandom);
      end
      abort = (c == abort_at);
      if (c < w) ret_in = 1'($urandom % 2);
      else       ret_in = (ret_at >= 0) && (c >= w + ret_at);
      #1;
      t       = $sformatf("%s c%0d", name, c);
      quiet   = (abort_at > 0) && (c >= abort_at);
      exp_rd  = !quiet && (c >= 2) && (c <= 1 + cnt);
      exp_ins = !quiet && (c >= 3) && (c <= 2 + cnt);
      errv    = (c == 0) ? model_err : ((c < done_c) ? 1'b0 : exp_err);
      chk({t, " arr_clr"}, 64'(arr_clr), 64'(c == 1));
      chk({t, " rd_en"},   64'(mem_rd_en), 64'(exp_rd));
      if (exp_rd) begin
        a = 10'(int'(base) + c - 2);
        chk({t, " rd_addr"}, 64'(mem_rd_addr), 64'(a));
      end
      word = 64'd0;
      if (exp_ins) word = mem[10'(int'(base) + c - 3)];
      chk({t, " i_en"},   64'(instr_en_out), 64'(exp_ins));
      chk({t, " i_data"}, 64'(instr_data_out), 64'(word[31:0]));
      chk({t, " i_addr"}, 64'(instr_addr_out), 64'(word[37:32]));
      chk({t, " i_hops"}, 64'(instr_hops_out), 64'(word[41:38]));
      chk({t, " call"},   64'(call_out), 64'(!quiet && c == call_c));
      chk({t, " done"},   64'(done), 64'(c == done_c));
      chk({t, " busy"},   64'(busy), 64'(c >= 1 && c <= done_c));
      chk({t, " error"},  64'(error), 64'(errv));
    end
    model_err = exp_err;
    start = 1'b0; abort = 1'b0; ret_in = 1'b0;
  endtask

  initial begin
    int rcnt, rret;
    logic [15:0] rtmo;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; ret_in = 1'b0;
    base_addr = '0; count = '0; timeout = '0;
    #3 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // abort while idle has no effect
    @(negedge clk);
    abort = 1'b1;
    #1 chk("idle_abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("idle_abort done", 64'(done), 64'd0);
    chk("idle_abort error", 64'(error), 64'd0);

    run_launch(10'h010, 3, 16'd0, 1, -1, "basic");
    run_launch(10'h155, 0, 16'd0, 0, -1, "cnt0");
    run_launch(10'h3FE, 4, 16'd0, 2, -1, "wrap");
    run_launch(10'h020, 2, 16'd5, -1, -1, "tmo_exp");
    run_launch(10'h030, 2, 16'd5, 4, -1, "tmo_ret");
    run_launch(10'($urandom), 5, 16'd0, 0, 3, "abort");
    run_launch(10'($urandom), 2, 16'd0, 0, -1, "after_abort");
    run_launch(10'($urandom), 256, 16'd3, 1, -1, "cnt256");

    for (int k = 0; k < 6; k++) begin
      rcnt = int'($urandom_range(0, 20));
      rtmo = 16'($urandom_range(0, 8));
      if (rtmo == 0)                    rret = int'($urandom_range(0, 6));
      else if ($urandom_range(0, 3) == 0) rret = -1;
      else                              rret = int'($urandom_range(0, 10));
      run_launch(10'($urandom), rcnt, rtmo, rret, -1, $sformatf("rand%0d", k));
    end

    // reset in the middle of a fetch burst
    @(negedge clk);
    start = 1'b1; base_addr = 10'h200; count = 9'd8; timeout = 16'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_fetch rd_en", 64'(mem_rd_en), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_fetch");
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst_hold done", 64'(done), 64'd0);
      chk("rst_hold busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("post_rst done", 64'(done), 64'd0);
      chk("post_rst busy", 64'(busy), 64'd0);
      chk("post_rst rd_en", 64'(mem_rd_en), 64'd0);
    end
    model_err = 1'b0;
    run_launch(10'h0A0, 3, 16'd4, 2, -1, "clean");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
